// File: rtl/approx_mon_pkg.sv
// Shared types, default sizing and helpers for the approximate-multiplier error monitor.
package approx_mon_pkg;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_WINDOW_LOG2 = 8;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DRAIN  = 2'd1,
    REPORT = 2'd2
  } mon_state_t;

  // Absolute-error sum width: room for 2^window_log2 maximal product-width errors.
  function automatic int unsigned acc_w(input int unsigned width, input int unsigned window_log2);
    return 2 * width + window_log2;
  endfunction

endpackage

// File: rtl/approx_err_calc.sv
// Combinational exact-vs-approximate product comparison: absolute error, error and over-estimate flags.
module approx_err_calc
  import approx_mon_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [2*WIDTH-1:0] in_p,
  output logic [2*WIDTH-1:0] ae,
  output logic               err,
  output logic               over
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0]      exact;
  logic signed [PW:0] diff;

  // Signed difference on one extra bit, folded to magnitude; |diff| always fits in PW bits.
  always_comb begin
    exact = PW'(in_a) * PW'(in_b);
    diff  = $signed({1'b0, exact}) - $signed({1'b0, in_p});
    ae    = diff[PW] ? PW'(-diff) : PW'(diff);
    err   = (ae != '0);
    over  = (in_p > exact);
  end

endmodule

// File: rtl/approx_mul_err_monitor.sv
// Windowed error-metric accumulator for an approximate multiplier, with valid/ready window reports.
module approx_mul_err_monitor
  import approx_mon_pkg::*;
#(
  parameter  int unsigned WIDTH       = DEF_WIDTH,
  parameter  int unsigned WINDOW_LOG2 = DEF_WINDOW_LOG2,
  localparam int unsigned ACC_W       = acc_w(WIDTH, WINDOW_LOG2)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  input  logic [2*WIDTH-1:0]     in_p,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_sum_ae,
  output logic [2*WIDTH-1:0]     out_mae,
  output logic [2*WIDTH-1:0]     out_max_ae,
  output logic [WINDOW_LOG2:0]   out_err_cnt,
  output logic [WINDOW_LOG2:0]   out_over_cnt
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = WINDOW_LOG2 + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'((1 << WINDOW_LOG2) - 1);

  mon_state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic             s1_vld, s1_err, s1_over;
  logic [PW-1:0]    s1_ae;
  logic [ACC_W-1:0] acc_sum;
  logic [PW-1:0]    acc_max;
  logic [CW-1:0]    acc_err, acc_over;

  logic [PW-1:0]    c_ae;
  logic             c_err, c_over;
  logic             accept, rpt_done;
  logic             in_ready_d, out_valid_d, load_rpt;

  assign accept   = in_valid & in_ready & ~clear;
  assign rpt_done = out_valid & out_ready;

  approx_err_calc #(.WIDTH(WIDTH)) u_calc (
    .in_a (in_a),
    .in_b (in_b),
    .in_p (in_p),
    .ae   (c_ae),
    .err  (c_err),
    .over (c_over)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  // Next-state logic; clear overrides every other event
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ACCUM;
    end else begin
      case (state)
        ACCUM:   if (accept && (cnt == LAST_IDX)) state_nxt = DRAIN;
        DRAIN:   state_nxt = REPORT;
        REPORT:  if (rpt_done) state_nxt = ACCUM;
        default: state_nxt = ACCUM;
      endcase
    end
  end

  // Output decode: next values of the handshake flags and the report-capture strobe
  always_comb begin
    in_ready_d  = (state_nxt == ACCUM);
    out_valid_d = ~clear & (state == REPORT) & ~rpt_done;
    load_rpt    = ~clear & (state == REPORT) & ~out_valid;
  end

  // Registered handshake flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  // Stage 1: capture per-sample error metrics on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_ae   <= '0;
      s1_err  <= 1'b0;
      s1_over <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_ae   <= c_ae;
        s1_err  <= c_err;
        s1_over <= c_over;
      end
    end
  end

  // Stage 2: accept counter and window accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc_sum  <= '0;
      acc_max  <= '0;
      acc_err  <= '0;
      acc_over <= '0;
    end else if (clear || rpt_done) begin
      cnt      <= '0;
      acc_sum  <= '0;
      acc_max  <= '0;
      acc_err  <= '0;
      acc_over <= '0;
    end else begin
      if (accept) cnt <= cnt + CW'(1);
      if (s1_vld) begin
        acc_sum  <= acc_sum + ACC_W'(s1_ae);
        acc_err  <= acc_err + CW'(s1_err);
        acc_over <= acc_over + CW'(s1_over);
        if (s1_ae > acc_max) acc_max <= s1_ae;
      end
    end
  end

  // Report registers, captured once on entry to REPORT and held until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum_ae   <= '0;
      out_mae      <= '0;
      out_max_ae   <= '0;
      out_err_cnt  <= '0;
      out_over_cnt <= '0;
    end else if (load_rpt) begin
      out_sum_ae   <= acc_sum;
      out_mae      <= PW'(acc_sum >> WINDOW_LOG2);
      out_max_ae   <= acc_max;
      out_err_cnt  <= acc_err;
      out_over_cnt <= acc_over;
    end
  end

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// Directed and random-soak bench for approx_mul_err_monitor (window-4 and window-256 instances).
module tb_approx_mul_err_monitor;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // Window-of-4 instance for directed scenarios
  logic        clear, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_a, in_b;
  logic [15:0] in_p;
  logic [17:0] out_sum_ae;
  logic [15:0] out_mae, out_max_ae;
  logic [2:0]  out_err_cnt, out_over_cnt;

  // Window-of-256 instance for the random soak
  logic        clear8, in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic [23:0] sum8;
  logic [15:0] mae8, max8;
  logic [8:0]  errc8, overc8;

  logic [15:0] c_ae;
  logic        c_err, c_over;

  approx_mul_err_monitor #(.WIDTH(8), .WINDOW_LOG2(2)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_p(in_p),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum_ae(out_sum_ae), .out_mae(out_mae), .out_max_ae(out_max_ae),
    .out_err_cnt(out_err_cnt), .out_over_cnt(out_over_cnt)
  );

  approx_mul_err_monitor #(.WIDTH(8), .WINDOW_LOG2(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .clear(clear8),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(a8), .in_b(b8), .in_p(p8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_sum_ae(sum8), .out_mae(mae8), .out_max_ae(max8),
    .out_err_cnt(errc8), .out_over_cnt(overc8)
  );

  approx_err_calc #(.WIDTH(8)) sb_calc (
    .in_a(a8), .in_b(b8), .in_p(p8),
    .ae(c_ae), .err(c_err), .over(c_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_p     = p;
    tick();
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic check_report(input string tag, input int sum, input int mae, input int mx,
                              input int ec, input int oc);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_sum"},   out_sum_ae, sum);
    check({tag, "_mae"},   out_mae, mae);
    check({tag, "_max"},   out_max_ae, mx);
    check({tag, "_err"},   out_err_cnt, ec);
    check({tag, "_over"},  out_over_cnt, oc);
  endtask

  // Soak scoreboard state
  logic [23:0] m_sum, e_sum;
  logic [15:0] m_max, e_max;
  logic [8:0]  m_err, m_over, e_err, e_over;
  int          m_cnt, reports, ex, pv;
  logic        pending;

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_p = '0;
    clear8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; p8 = '0;

    // Reset state
    #2 rst_n = 1'b0;
    tick(); tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", out_sum_ae, 0);
    check("rst_max", out_max_ae, 0);
    check("rst_err", out_err_cnt, 0);
    check("rst_over", out_over_cnt, 0);
    check("rst_mae", out_mae, 0);
    rst_n = 1'b1;
    tick();

    // Exact stream, with report latency of two edges after the last accept
    repeat (4) send(8'd3, 8'd5, 16'd15);
    in_valid = 1'b0;
    check("exact_ready_drain", in_ready, 0);
    check("exact_valid_t0", out_valid, 0);
    tick();
    check("exact_valid_t1", out_valid, 0);
    check("exact_ready_t1", in_ready, 0);
    tick();
    check_report("exact", 0, 0, 0, 0, 0);
    handshake();
    check("exact_ready_after", in_ready, 1);
    check("exact_valid_after", out_valid, 0);

    // Mixed errors: ae = 0, 2 (over), 4 (under), 0
    send(8'd255, 8'd255, 16'd65025);
    send(8'd2, 8'd2, 16'd6);
    send(8'd10, 8'd10, 16'd96);
    send(8'd0, 8'd7, 16'd0);
    in_valid = 1'b0;
    tick(); tick();
    check_report("mixed", 6, 1, 4, 2, 1);

    // Backpressure: report held, input stalled, offered samples ignored
    for (int i = 0; i < 10; i++) begin
      send(8'd1, 8'd1, 16'd0);
      check("bp_valid", out_valid, 1);
      check("bp_ready", in_ready, 0);
      check("bp_sum", out_sum_ae, 6);
      check("bp_max", out_max_ae, 4);
    end
    in_valid = 1'b0;
    handshake();
    check("bp_ready_after", in_ready, 1);
    repeat (4) send(8'd3, 8'd3, 16'd8);
    in_valid = 1'b0;
    tick(); tick();
    check_report("bp_next", 4, 1, 1, 4, 0);
    handshake();

    // Clear colliding with the third accept flushes the partial window
    send(8'd9, 8'd9, 16'd0);
    send(8'd9, 8'd9, 16'd0);
    clear = 1'b1;
    send(8'd9, 8'd9, 16'd0);
    clear = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("clr_no_valid", out_valid, 0);
      check("clr_ready", in_ready, 1);
      tick();
    end
    repeat (4) send(8'd1, 8'd1, 16'd0);
    in_valid = 1'b0;
    tick();
    check("clr_valid_early", out_valid, 0);
    tick();
    check_report("clr", 4, 1, 1, 4, 0);
    handshake();

    // Async reset while in DRAIN
    repeat (4) send(8'd4, 8'd4, 16'd0);
    in_valid = 1'b0;
    check("ar_in_drain", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_ready", in_ready, 1);
    check("ar_sum", out_sum_ae, 0);
    check("ar_mae", out_mae, 0);
    check("ar_max", out_max_ae, 0);
    check("ar_err", out_err_cnt, 0);
    check("ar_over", out_over_cnt, 0);
    #1 rst_n = 1'b1;
    tick(); tick(); tick();
    check("ar_no_report", out_valid, 0);
    check("ar_ready_idle", in_ready, 1);
    repeat (4) send(8'd2, 8'd3, 16'd7);
    in_valid = 1'b0;
    tick(); tick();
    check_report("ar_fresh", 4, 1, 1, 4, 4);
    handshake();

    // Random soak on the 256-sample window
    m_sum = '0; m_max = '0; m_err = '0; m_over = '0; m_cnt = 0;
    e_sum = '0; e_max = '0; e_err = '0; e_over = '0;
    pending = 1'b0; reports = 0;
    for (int cyc = 0; cyc < 4000 && reports < 2; cyc++) begin
      @(negedge clk);
      in_valid8  = ($urandom_range(0, 3) != 0);
      out_ready8 = ($urandom_range(0, 2) == 0);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      ex = int'(a8) * int'(b8);
      case ($urandom_range(0, 3))
        0: pv = ex;
        1: begin pv = ex + int'($urandom_range(1, 40)); if (pv > 65535) pv = 65535; end
        2: begin pv = ex - int'($urandom_range(1, 40)); if (pv < 0) pv = 0; end
        default: pv = int'($urandom_range(0, 65535));
      endcase
      p8 = 16'(pv);
      #1;
      if (out_valid8 && out_ready8) begin
        check("soak_expected_report", pending, 1);
        check("soak_sum", sum8, e_sum);
        check("soak_mae", mae8, 32'(e_sum >> 8));
        check("soak_max", max8, e_max);
        check("soak_err", errc8, e_err);
        check("soak_over", overc8, e_over);
        pending = 1'b0;
        reports++;
      end
      if (in_valid8 && in_ready8) begin
        m_sum  = m_sum + 24'(c_ae);
        m_err  = m_err + 9'(c_err);
        m_over = m_over + 9'(c_over);
        if (c_ae > m_max) m_max = c_ae;
        m_cnt++;
        if (m_cnt == 256) begin
          e_sum = m_sum; e_max = m_max; e_err = m_err; e_over = m_over;
          pending = 1'b1;
          m_sum = '0; m_max = '0; m_err = '0; m_over = '0; m_cnt = 0;
        end
      end
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b0;
    check("soak_reports", reports, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
